// File: rtl/wave_osc_if.sv
// Control and sample bus of the wave_osc oscillator.
// The master drives the waveform controls; the slave returns samples and the wrap strobe.
interface wave_osc_if #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned OUT_W = 32
);
   logic             en;
   logic [1:0]       mode;
   logic [CNT_W-1:0] wave_length;
   logic [CNT_W-1:0] duty;
   logic [OUT_W-1:0] out;
   logic             out_valid;
   logic             wrap;

   modport master (
      output en, mode, wave_length, duty,
      input  out, out_valid, wrap
   );

   modport slave (
      input  en, mode, wave_length, duty,
      output out, out_valid, wrap
   );
endinterface

// File: rtl/wave_osc.sv
// Period-counter oscillator. A serial restoring divider produces the phase q = num/den
// in FRAC fractional bits, which is then shaped into a saw, square, triangle or mute sample.
module wave_osc #(
   parameter int unsigned CNT_W = 32,
   parameter int unsigned FRAC  = 20,
   parameter int unsigned OUT_W = 32
) (
   input logic       clk,
   input logic       rst_n,
   wave_osc_if.slave bus
);
   localparam int unsigned W  = FRAC + 3;
   localparam int unsigned SW = $clog2(FRAC + 1);
   localparam logic signed [W-1:0] ONE   = W'(1) << FRAC;
   localparam logic signed [W-1:0] HALF  = ONE >>> 1;
   localparam logic signed [W-1:0] THREE = ONE + (ONE <<< 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             armed_q;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [CNT_W-1:0] den_q, den_d;
   logic [FRAC:0]    q_q, q_d;
   logic [SW-1:0]    step_q, step_d;
   logic [1:0]       mode_q, mode_d;
   logic             sq_hi_q, sq_hi_d;
   logic             dz_q, dz_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic             ge;
   logic [CNT_W:0]   diff;
   logic signed [W-1:0] qs;
   logic signed [W-1:0] wave;

   // Period register only reloads at a wrap (or while idle at zero), so a new
   // wave_length never shortens or stretches the period already in progress.
   always_comb begin
      cnt_d    = cnt_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      if (period_q == '0) begin
         cnt_d    = '0;
         period_d = bus.wave_length;
      end else if (bus.en) begin
         if (cnt_q < period_q) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            cnt_d    = '0;
            wrap_d   = 1'b1;
            period_d = bus.wave_length;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      den_d       = den_q;
      q_d         = q_q;
      step_d      = step_q;
      mode_d      = mode_q;
      sq_hi_d     = sq_hi_q;
      dz_d        = dz_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      ge          = 1'b0;
      diff        = rem_q;
      qs          = '0;
      wave        = '0;
      case (state_q)
         S_IDLE: begin
            if (bus.en && armed_q) begin
               rem_d   = {1'b0, cnt_q};
               den_d   = period_q;
               q_d     = '0;
               step_d  = '0;
               mode_d  = bus.mode;
               sq_hi_d = (cnt_q < bus.duty);
               dz_d    = (period_q == '0);
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            // rem_q is already the trial value; shifting after subtraction keeps
            // the first step (integer bit of q) identical to the fractional steps.
            ge      = (rem_q >= {1'b0, den_q});
            diff    = ge ? (rem_q - {1'b0, den_q}) : rem_q;
            rem_d   = {diff[CNT_W-1:0], 1'b0};
            q_d     = {q_q[FRAC-1:0], ge};
            step_d  = step_q + 1'b1;
            if (step_q == SW'(FRAC)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            qs = dz_q ? '0 : signed'(W'(q_q));
            case (mode_q)
               2'd0:    wave = (qs <<< 1) - ONE;
               2'd1:    wave = sq_hi_q ? ONE : -ONE;
               2'd2:    wave = (qs < HALF) ? ((qs <<< 2) - ONE) : (THREE - (qs <<< 2));
               default: wave = '0;
            endcase
            out_d       = OUT_W'(wave);
            out_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         period_q    <= '0;
         wrap_q      <= 1'b0;
         armed_q     <= 1'b0;
         rem_q       <= '0;
         den_q       <= '0;
         q_q         <= '0;
         step_q      <= '0;
         mode_q      <= '0;
         sq_hi_q     <= 1'b0;
         dz_q        <= 1'b0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         period_q    <= period_d;
         wrap_q      <= wrap_d;
         armed_q     <= 1'b1;
         rem_q       <= rem_d;
         den_q       <= den_d;
         q_q         <= q_d;
         step_q      <= step_d;
         mode_q      <= mode_d;
         sq_hi_q     <= sq_hi_d;
         dz_q        <= dz_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.out       = out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_wave_osc.sv
// Directed bench for wave_osc: a vector table over waveform shapes plus sequences
// for period change, zero period, reset during division and enable gating.
module tb_wave_osc;
   localparam int ONE = 1048576;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;
   int   ecnt;
   int   wrap_mode = 0;

   wave_osc_if #(.CNT_W(32), .OUT_W(32)) bus ();

   wave_osc #(.CNT_W(32), .FRAC(20), .OUT_W(32)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Rising edges seen since the last reset release.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   typedef struct {
      logic [1:0]  mode;
      logic [31:0] duty;
      int          exp;
   } vec_t;

   vec_t tbl[15];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, ecnt);
      end
   endtask

   function automatic logic exp_wrap(input int m, input int e);
      case (m)
         1:       return (e >= 6) && (((e - 6) % 5) == 0);
         2:       return (e >= 6) && (((e - 6) % 10) == 0);
         default: return 1'b0;
      endcase
   endfunction

   always @(negedge clk) begin
      if (wrap_mode != 0) chk("wrap", longint'(bus.wrap), longint'(exp_wrap(wrap_mode, ecnt)));
   end

   task automatic start(input logic [31:0] wl, input logic [1:0] m, input logic [31:0] d);
      rst_n = 1'b0;
      bus.en = 1'b0;
      bus.wave_length = wl;
      bus.mode = m;
      bus.duty = d;
      repeat (2) @(negedge clk);
      bus.en = 1'b1;
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(input int limit, output int at);
      at = -1;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            at = ecnt;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         failures++;
         $display("FAIL out_valid_timeout actual=none required=pulse within %0d cycles", limit);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int at;
      int nv;
      int outv;

      tbl[0]  = '{2'd0, 32'd0, -ONE};
      tbl[1]  = '{2'd2, 32'd0, 0};
      tbl[2]  = '{2'd1, 32'd2, ONE};
      tbl[3]  = '{2'd0, 32'd0, ONE};
      tbl[4]  = '{2'd0, 32'd0, 0};
      tbl[5]  = '{2'd2, 32'd0, -ONE};
      tbl[6]  = '{2'd1, 32'd2, -ONE};
      tbl[7]  = '{2'd2, 32'd0, 0};
      tbl[8]  = '{2'd3, 32'd0, 0};
      tbl[9]  = '{2'd2, 32'd0, ONE};
      tbl[10] = '{2'd1, 32'd0, -ONE};
      tbl[11] = '{2'd0, 32'd0, 524288};
      tbl[12] = '{2'd0, 32'd0, -524288};
      tbl[13] = '{2'd2, 32'd0, -ONE};
      tbl[14] = '{2'd1, 32'd3, ONE};

      // Reset state, applied between clock edges
      rst_n = 1'b1;
      bus.en = 1'b0;
      bus.mode = 2'd0;
      bus.wave_length = 32'd4;
      bus.duty = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out", longint'($signed(bus.out)), 0);
      chk("rst_valid", longint'(bus.out_valid), 0);
      chk("rst_wrap", longint'(bus.wrap), 0);
      chk("rst_cnt", longint'(dut.cnt_q), 0);
      chk("rst_period", longint'(dut.period_q), 0);

      // Table: period 5, en held high; captures land on counter 0,3,1,4,2,...
      start(32'd4, tbl[0].mode, tbl[0].duty);
      wrap_mode = 1;
      for (int j = 0; j < 15; j++) begin
         repeat (3) @(negedge clk);
         bus.mode = ~tbl[j].mode;
         bus.duty = 32'd100;
         wait_valid(40, at);
         chk($sformatf("tbl_lat[%0d]", j), at, 24 + 23 * j);
         chk($sformatf("tbl_out[%0d]", j), longint'($signed(bus.out)), tbl[j].exp);
         if (j < 14) begin
            bus.mode = tbl[j+1].mode;
            bus.duty = tbl[j+1].duty;
         end
      end
      wrap_mode = 0;

      // Period change from 4 to 9 while counter is 2
      start(32'd4, 2'd0, 32'd0);
      wrap_mode = 2;
      repeat (3) @(negedge clk);
      chk("pc_cnt", longint'(dut.cnt_q), 2);
      bus.wave_length = 32'd9;
      repeat (30) @(negedge clk);
      wrap_mode = 0;

      // Zero period: saw then mute, counter pinned at 0, no wraps
      start(32'd0, 2'd0, 32'd0);
      wrap_mode = 3;
      for (int k = 0; k < 4; k++) begin
         wait_valid(40, at);
         chk($sformatf("zp_lat[%0d]", k), at, 24 + 23 * k);
         chk($sformatf("zp_out[%0d]", k), longint'($signed(bus.out)), (k < 2) ? -ONE : 0);
         chk($sformatf("zp_cnt[%0d]", k), longint'(dut.cnt_q), 0);
         if (k == 1) bus.mode = 2'd3;
      end
      wrap_mode = 0;

      // Reset asserted mid-division of the second sample
      start(32'd4, 2'd0, 32'd0);
      wait_valid(40, at);
      chk("rd_first_out", longint'($signed(bus.out)), -ONE);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rd_out", longint'($signed(bus.out)), 0);
      chk("rd_valid", longint'(bus.out_valid), 0);
      chk("rd_cnt", longint'(dut.cnt_q), 0);
      chk("rd_period", longint'(dut.period_q), 0);
      @(negedge clk);
      chk("rd_valid_hold", longint'(bus.out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_valid(60, at);
      chk("rd_release_lat", at, 24);

      // Enable dropped mid-division: one sample completes, counter freezes
      start(32'd9, 2'd0, 32'd0);
      repeat (5) @(negedge clk);
      bus.en = 1'b0;
      nv = 0;
      outv = 12345;
      for (int i = 0; i < 55; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            nv++;
            outv = $signed(bus.out);
         end
      end
      chk("gate_valid_count", nv, 1);
      chk("gate_out", outv, -ONE);
      chk("gate_cnt_frozen", longint'(dut.cnt_q), 4);
      bus.en = 1'b1;
      @(negedge clk);
      chk("gate_cnt_resume", longint'(dut.cnt_q), 5);
      wait_valid(40, at);
      chk("gate_lat", at, 83);
      chk("gate_out2", longint'($signed(bus.out)), -116510);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
